// File: rtl/cpu_sd_cmd.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sd_cmd
// Description : CPU-bus peripheral driving the SD card CMD line. Generates
//               sd_clk, serialises 48-bit commands with CRC7, and optionally
//               captures and checks a 48-bit response.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sd_cmd #(
    parameter int         RSP_TIMEOUT = 64,
    parameter logic [7:0] DIV_RESET   = 8'd124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_request,
    input  logic [3:0]  bus_wmask,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic        sd_clk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_WAIT = 2'd2,
        S_RX   = 2'd3
    } state_t;

    state_t      r_state, w_state_next;

    logic        r_clk_en;
    logic [7:0]  r_div;
    logic [7:0]  r_div_act;      // divider frozen for the running command
    logic [31:0] r_arg;
    logic [31:0] r_rsp;
    logic [5:0]  r_rx_index;
    logic        r_timeout;
    logic        r_crc_err;
    logic [1:0]  r_rsp_type;
    logic [7:0]  r_cnt;
    logic [47:0] r_tx_shift;
    logic [47:0] r_rx_shift;
    logic [5:0]  r_bit_cnt;
    logic [15:0] r_wait_cnt;

    // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    logic [1:0]  w_reg;
    logic        w_busy;
    logic        w_start;
    logic [39:0] w_tx_head;
    logic [47:0] w_rx_frame;
    logic        w_run;
    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic [7:0]  w_reload;
    logic [31:0] w_rd;
    logic        w_unused;

    assign w_reg      = bus_address[3:2];
    assign w_unused   = ^{bus_address[31:4], bus_address[1:0]};
    assign w_busy     = (r_state != S_IDLE);
    assign w_start    = bus_request & bus_wmask[0] & (w_reg == 2'd2) & ~w_busy;
    assign w_tx_head  = {2'b01, bus_wdata[5:0], r_arg};
    assign w_rx_frame = {r_rx_shift[46:0], sd_cmd_i};

    assign w_run    = r_clk_en | w_busy;
    assign w_reload = w_busy ? r_div_act : r_div;
    assign w_tick   = w_run & (r_cnt == 8'd0);
    assign w_rise   = w_tick & ~sd_clk;
    assign w_fall   = w_tick & sd_clk;

    // sd_clk divider: half period is div+1 clk cycles, parked low when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= DIV_RESET;
            sd_clk <= 1'b0;
        end else if (!w_run) begin
            r_cnt  <= r_div;
            sd_clk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= w_reload;
            sd_clk <= ~sd_clk;
        end else begin
            r_cnt  <= r_cnt - 8'd1;
        end
    end

    // Register read mux; CTRL reflects the pre-update busy flag
    always_comb begin
        w_rd = 32'd0;
        case (w_reg)
            2'd0: w_rd = {16'd0, r_div, 4'd0, r_clk_en, r_crc_err, r_timeout, w_busy};
            2'd1: w_rd = r_arg;
            2'd2: w_rd = {26'd0, r_rx_index};
            2'd3: w_rd = r_rsp;
            default: w_rd = 32'd0;
        endcase
    end

    // Bus handshake and writable control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= 32'd0;
            r_clk_en  <= 1'b0;
            r_div     <= DIV_RESET;
            r_arg     <= 32'd0;
        end else begin
            bus_ack   <= bus_request;
            bus_rdata <= (bus_request && bus_wmask == 4'd0) ? w_rd : 32'd0;
            if (bus_request && w_reg == 2'd0) begin
                if (bus_wmask[0]) r_clk_en <= bus_wdata[3];
                if (bus_wmask[1]) r_div    <= bus_wdata[15:8];
            end
            if (bus_request && w_reg == 2'd1) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_wmask[b]) r_arg[8*b +: 8] <= bus_wdata[8*b +: 8];
                end
            end
        end
    end

    // Event flags decoded from the current state and clock strobes
    logic w_tx_bit, w_tx_end, w_rx_start, w_wait_inc, w_wait_to, w_rx_bit, w_rx_end;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next-state and event decode
    always_comb begin
        w_state_next = r_state;
        w_tx_bit     = 1'b0;
        w_tx_end     = 1'b0;
        w_rx_start   = 1'b0;
        w_wait_inc   = 1'b0;
        w_wait_to    = 1'b0;
        w_rx_bit     = 1'b0;
        w_rx_end     = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = S_TX;
            S_TX: begin
                if (w_fall) begin
                    if (r_bit_cnt != 6'd0) begin
                        w_tx_bit = 1'b1;
                    end else begin
                        w_tx_end     = 1'b1;
                        w_state_next = (r_rsp_type == 2'd0) ? S_IDLE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    if (!sd_cmd_i) begin
                        w_rx_start   = 1'b1;
                        w_state_next = S_RX;
                    end else if (r_wait_cnt == 16'(RSP_TIMEOUT - 1)) begin
                        w_wait_to    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_wait_inc   = 1'b1;
                    end
                end
            end
            S_RX: begin
                if (w_rise) begin
                    w_rx_bit = 1'b1;
                    if (r_bit_cnt == 6'd1) begin
                        w_rx_end     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command shift-out, response shift-in and status latching
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_cmd_o   <= 1'b1;
            sd_cmd_oe  <= 1'b0;
            r_tx_shift <= 48'd0;
            r_rx_shift <= 48'd0;
            r_bit_cnt  <= 6'd0;
            r_wait_cnt <= 16'd0;
            r_rsp_type <= 2'd0;
            r_div_act  <= DIV_RESET;
            r_timeout  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_rsp      <= 32'd0;
            r_rx_index <= 6'd0;
        end else begin
            if (w_start) begin
                r_timeout  <= 1'b0;
                r_crc_err  <= 1'b0;
                r_tx_shift <= {w_tx_head, crc7(w_tx_head), 1'b1};
                r_bit_cnt  <= 6'd48;
                r_rsp_type <= bus_wdata[7:6];
                r_div_act  <= r_div;
            end
            if (w_tx_bit) begin
                sd_cmd_o   <= r_tx_shift[47];
                sd_cmd_oe  <= 1'b1;
                r_tx_shift <= {r_tx_shift[46:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt - 6'd1;
            end
            if (w_tx_end) begin
                sd_cmd_o   <= 1'b1;
                sd_cmd_oe  <= 1'b0;
                r_wait_cnt <= 16'd0;
            end
            if (w_wait_inc) r_wait_cnt <= r_wait_cnt + 16'd1;
            if (w_wait_to)  r_timeout  <= 1'b1;
            if (w_rx_start) begin
                r_rx_shift <= w_rx_frame;
                r_bit_cnt  <= 6'd47;
            end
            if (w_rx_bit) begin
                r_rx_shift <= w_rx_frame;
                r_bit_cnt  <= r_bit_cnt - 6'd1;
            end
            if (w_rx_end) begin
                r_rsp      <= w_rx_frame[39:8];
                r_rx_index <= w_rx_frame[45:40];
                r_crc_err  <= ~w_rx_frame[0] |
                              ((r_rsp_type != 2'd2) &&
                               (w_rx_frame[7:1] != crc7(w_rx_frame[47:8])));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sd_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sd_cmd
// Description : Self-checking bench for cpu_sd_cmd: register vectors, command
//               framing, card responses, CRC errors, timeout, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sd_cmd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_request = 1'b0;
    logic [3:0]  bus_wmask = 4'd0;
    logic [31:0] bus_address = 32'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        sd_clk;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        sd_cmd_i = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_sd_cmd dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_request (bus_request),
        .bus_wmask   (bus_wmask),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .sd_clk      (sd_clk),
        .sd_cmd_o    (sd_cmd_o),
        .sd_cmd_oe   (sd_cmd_oe),
        .sd_cmd_i    (sd_cmd_i)
    );

    // Card-side view of the transmitted frame: sample CMD on sd_clk rising
    logic [47:0] cap = 48'd0;
    int          cap_cnt = 0;
    always @(posedge sd_clk) begin
        if (sd_cmd_oe) begin
            cap     <= {cap[46:0], sd_cmd_o};
            cap_cnt <= cap_cnt + 1;
        end
    end

    // Count CMD output changes that do not coincide with an sd_clk fall
    logic prev_o = 1'b1, prev_sck = 1'b0, prev_rst = 1'b0;
    int   viol = 0;
    always @(negedge clk) begin
        if (reset_n && prev_rst && (sd_cmd_o !== prev_o) && !(prev_sck && !sd_clk))
            viol <= viol + 1;
        prev_o   <= sd_cmd_o;
        prev_sck <= sd_clk;
        prev_rst <= reset_n;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event expected event", name);
    endtask

    // One bus access; caller is positioned at a falling clk edge
    task automatic bus(input logic [1:0] r, input logic [3:0] wm, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ack);
        bus_request = 1'b1;
        bus_address = {28'd0, r, 2'b00};
        bus_wmask   = wm;
        bus_wdata   = wd;
        @(negedge clk);
        ack = bus_ack;
        rd  = bus_rdata;
        bus_request = 1'b0;
        bus_wmask   = 4'd0;
        bus_wdata   = 32'd0;
    endtask

    task automatic rd_reg(input logic [1:0] r, output logic [31:0] d);
        logic a;
        bus(r, 4'd0, 32'd0, d, a);
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [3:0] wm, input logic [31:0] wd);
        logic [31:0] d;
        logic a;
        bus(r, wm, wd, d, a);
    endtask

    task automatic wait_edge(input bit rising);
        logic p;
        p = sd_clk;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rising ? (!p && sd_clk) : (p && !sd_clk)) return;
            p = sd_clk;
        end
        timeout_fail("sd_clk_edge");
    endtask

    task automatic wait_oe_release();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sd_cmd_oe) seen = 1'b1;
            else if (seen) return;
        end
        timeout_fail("oe_release");
    endtask

    task automatic wait_bits(input int base, input int n);
        for (int k = 0; k < 3000; k++) begin
            if (cap_cnt - base >= n) return;
            @(negedge clk);
        end
        timeout_fail("tx_bits");
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        for (int k = 0; k < 2000; k++) begin
            rd_reg(2'd0, d);
            if (!d[0]) return;
        end
        timeout_fail("busy_clear");
    endtask

    // Card model: reply five sd_clk cycles after the host releases CMD
    task automatic card_reply(input logic [47:0] f);
        wait_oe_release();
        repeat (5) wait_edge(1'b0);
        for (int i = 47; i >= 0; i--) begin
            sd_cmd_i = f[i];
            wait_edge(1'b0);
        end
        sd_cmd_i = 1'b1;
    endtask

    // CMD8 with argument 0x1AA, card replies with the given frame
    task automatic run_r48(input string name, input logic [7:0] cmd,
                           input logic [47:0] reply, input logic [31:0] exp_ctrl);
        logic [31:0] d;
        int c0;
        wr_reg(2'd1, 4'hF, 32'h0000_01AA);
        c0 = cap_cnt;
        wr_reg(2'd2, 4'h1, {24'd0, cmd});
        card_reply(reply);
        chk({name, "_frame"}, cap, 48'h48_0000_01AA_87);
        chk({name, "_nbits"}, 48'(cap_cnt - c0), 48'd48);
        wait_idle();
        rd_reg(2'd0, d); chk({name, "_ctrl"}, 48'(d), 48'(exp_ctrl));
        rd_reg(2'd3, d); chk({name, "_rsp"},  48'(d), 48'h0000_01AA);
        rd_reg(2'd2, d); chk({name, "_idx"},  48'(d), 48'h08);
    endtask

    typedef struct {
        logic [1:0]  r;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [31:0] d;
        logic        a;
        int          c0;

        vt[0]  = '{2'd0, 4'h0, 32'h0,          32'h0000_7C00};
        vt[1]  = '{2'd1, 4'h0, 32'h0,          32'h0};
        vt[2]  = '{2'd2, 4'h0, 32'h0,          32'h0};
        vt[3]  = '{2'd3, 4'h0, 32'h0,          32'h0};
        vt[4]  = '{2'd1, 4'h3, 32'h1234_5678,  32'h0};
        vt[5]  = '{2'd1, 4'h0, 32'h0,          32'h0000_5678};
        vt[6]  = '{2'd1, 4'hC, 32'hAABB_CCDD,  32'h0};
        vt[7]  = '{2'd1, 4'h0, 32'h0,          32'hAABB_5678};
        vt[8]  = '{2'd0, 4'h1, 32'hFFFF_FFFF,  32'h0};
        vt[9]  = '{2'd0, 4'h0, 32'h0,          32'h0000_7C08};
        vt[10] = '{2'd0, 4'h2, 32'h0000_0100,  32'h0};
        vt[11] = '{2'd0, 4'h0, 32'h0,          32'h0000_0108};
        vt[12] = '{2'd3, 4'hF, 32'hFFFF_FFFF,  32'h0};
        vt[13] = '{2'd3, 4'h0, 32'h0,          32'h0};

        repeat (3) @(negedge clk);
        chk("reset_oe", 48'(sd_cmd_oe), 48'd0);
        chk("reset_cmd_o", 48'(sd_cmd_o), 48'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Register vectors
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("v%0d_ack_idle", i), 48'(bus_ack), 48'd0);
            bus(vt[i].r, vt[i].wm, vt[i].wd, d, a);
            chk($sformatf("v%0d_ack", i), 48'(a), 48'd1);
            if (vt[i].wm == 4'd0) chk($sformatf("v%0d_rdata", i), 48'(d), 48'(vt[i].exp));
            @(negedge clk);
            chk($sformatf("v%0d_ack_drop", i), 48'(bus_ack), 48'd0);
        end

        // CMD0, no response
        wr_reg(2'd1, 4'hF, 32'h0);
        c0 = cap_cnt;
        wr_reg(2'd2, 4'h1, 32'h00);
        wait_oe_release();
        chk("cmd0_frame", cap, 48'h40_0000_0000_95);
        chk("cmd0_nbits", 48'(cap_cnt - c0), 48'd48);
        rd_reg(2'd0, d);
        chk("cmd0_ctrl", 48'(d), 48'h0108);
        chk("cmd0_oe", 48'(sd_cmd_oe), 48'd0);

        // CMD8 responses: good, bad CRC, bad CRC unchecked, bad end bit
        run_r48("r48_ok",     8'h48, 48'h08_0000_01AA_13, 32'h0108);
        run_r48("r48_badcrc", 8'h48, 48'h08_0000_01AA_15, 32'h010C);
        run_r48("r48_nocrc",  8'h88, 48'h08_0000_01AA_15, 32'h0108);
        run_r48("r48_endbit", 8'hC8, 48'h08_0000_01AA_12, 32'h010C);

        // Timeout: silent card, flag set on the 64th rise after release
        wr_reg(2'd2, 4'h1, 32'h48);
        wait_oe_release();
        repeat (63) wait_edge(1'b1);
        rd_reg(2'd0, d);
        chk("to_rise63", 48'(d), 48'h0109);
        wait_edge(1'b1);
        rd_reg(2'd0, d);
        chk("to_rise64", 48'(d), 48'h010A);
        wr_reg(2'd2, 4'h1, 32'h00);
        rd_reg(2'd0, d);
        chk("to_cleared", 48'(d), 48'h0109);
        wait_oe_release();
        rd_reg(2'd0, d);
        chk("to_next_done", 48'(d), 48'h0108);
        chk("edge_viol", 48'(viol), 48'd0);

        // Reset in the middle of a transmission
        wr_reg(2'd1, 4'hF, 32'h0000_01AA);
        c0 = cap_cnt;
        wr_reg(2'd2, 4'h1, 32'h48);
        wait_bits(c0, 20);
        reset_n = 1'b0;
        #1;
        chk("rst_oe", 48'(sd_cmd_oe), 48'd0);
        chk("rst_sdclk", 48'(sd_clk), 48'd0);
        chk("rst_cmd_o", 48'(sd_cmd_o), 48'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(2'd0, d);
        chk("rst_ctrl", 48'(d), 48'h7C00);
        rd_reg(2'd1, d);
        chk("rst_arg", 48'(d), 48'h0);

        // Command write while busy must not disturb the frame in flight
        wr_reg(2'd0, 4'h3, 32'h0000_0108);
        wr_reg(2'd1, 4'hF, 32'h0000_01AA);
        c0 = cap_cnt;
        wr_reg(2'd2, 4'h1, 32'h48);
        wait_bits(c0, 10);
        wr_reg(2'd2, 4'h1, 32'h00);
        wait_oe_release();
        chk("busy_frame", cap, 48'h48_0000_01AA_87);
        chk("busy_nbits", 48'(cap_cnt - c0), 48'd48);
        wait_idle();
        rd_reg(2'd0, d);
        chk("busy_ctrl", 48'(d), 48'h010A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
